// File: rtl/stack_exec_unit.sv
// Stream-fed stack execution core: accepts 16-bit instructions over valid/ready and
// runs them against an internal operand stack, latching a sticky error code on faults.
module stack_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    input  logic [INSTR_WIDTH-1:0]         instr,
    output logic                           instr_ready,
    output logic [DATA_WIDTH-1:0]          tos,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           busy,
    output logic                           halted,
    output logic                           err,
    output logic [2:0]                     err_code
);
    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int DW   = AW + 1;
    localparam int IMMW = INSTR_WIDTH - 5;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_POP2   = 3'd2;
    localparam logic [2:0] S_POP1   = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_PUSH2  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [4:0] OP_PUSH = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_MOD  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_INV  = 5'b01000;
    localparam logic [4:0] OP_DUP  = 5'b01001;
    localparam logic [4:0] OP_SWAP = 5'b01010;
    localparam logic [4:0] OP_DROP = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [DW-1:0] D_ONE   = DW'(1);
    localparam logic [DW-1:0] D_TWO   = DW'(2);
    localparam logic [DW-1:0] D_THREE = DW'(3);
    localparam logic [DW:0]   D_FULL  = (DW+1)'(STACK_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] alu(input logic [4:0] op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_DIV:  r = (b == '0) ? '0 : a / b;
            OP_MOD:  r = (b == '0) ? '0 : a % b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [2:0]             state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DW-1:0]          depth_q, depth_d;
    logic [DATA_WIDTH-1:0]  tos_q, tos_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic                   err_q, err_d, halted_q, halted_d, busy_q, busy_d;
    logic [2:0]             err_code_q, err_code_d;
    logic [DATA_WIDTH-1:0]  stack_q [STACK_DEPTH];

    logic                   wr_en_s;
    logic [DATA_WIDTH-1:0]  wr_data_s;
    logic [4:0]             op_s;
    logic [DW:0]            pops_s, pushes_s, after_s;
    logic                   illegal_s;
    logic [DW-1:0]          dm1_s, dm2_s, dm3_s;

    assign op_s  = instr_q[INSTR_WIDTH-1 -: 5];
    assign dm1_s = depth_q - D_ONE;
    assign dm2_s = depth_q - D_TWO;
    assign dm3_s = depth_q - D_THREE;

    // Per-opcode stack effect used by the DECODE checks
    always_comb begin
        pops_s    = '0;
        pushes_s  = '0;
        illegal_s = 1'b0;
        case (op_s)
            OP_PUSH:                                    pushes_s = (DW+1)'(1);
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
            OP_AND, OP_OR:                      begin pops_s = (DW+1)'(2); pushes_s = (DW+1)'(1); end
            OP_INV:                             begin pops_s = (DW+1)'(1); pushes_s = (DW+1)'(1); end
            OP_DUP:                             begin pops_s = (DW+1)'(1); pushes_s = (DW+1)'(2); end
            OP_SWAP:                            begin pops_s = (DW+1)'(2); pushes_s = (DW+1)'(2); end
            OP_DROP:                                    pops_s   = (DW+1)'(1);
            OP_HALT:                                    pops_s   = '0;
            default:                                    illegal_s = 1'b1;
        endcase
        after_s = {1'b0, depth_q} - pops_s + pushes_s;
    end

    // Next-state, datapath and error logic
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        depth_d    = depth_q;
        tos_d      = tos_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        wr_en_s    = 1'b0;
        wr_data_s  = '0;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (illegal_s) begin
                    err_d = 1'b1; err_code_d = 3'd4; state_d = S_ERROR;
                end else if ({1'b0, depth_q} < pops_s) begin
                    err_d = 1'b1; err_code_d = 3'd1; state_d = S_ERROR;
                end else if (after_s > D_FULL) begin
                    err_d = 1'b1; err_code_d = 3'd2; state_d = S_ERROR;
                end else if ((op_s == OP_DIV || op_s == OP_MOD) && tos_q == '0) begin
                    err_d = 1'b1; err_code_d = 3'd3; state_d = S_ERROR;
                end else if (op_s == OP_PUSH) begin
                    state_d = S_PUSH;
                end else if (op_s == OP_HALT) begin
                    state_d = S_HALT;
                end else if (pops_s == (DW+1)'(2)) begin
                    state_d = S_POP2;
                end else begin
                    state_d = S_POP1;
                end
            end
            S_POP2: begin
                b_d     = stack_q[dm1_s[AW-1:0]];
                a_d     = stack_q[dm2_s[AW-1:0]];
                res_d   = alu(op_s, stack_q[dm2_s[AW-1:0]], stack_q[dm1_s[AW-1:0]]);
                depth_d = dm2_s;
                tos_d   = (depth_q >= D_THREE) ? stack_q[dm3_s[AW-1:0]] : '0;
                state_d = S_PUSH;
            end
            S_POP1: begin
                a_d     = stack_q[dm1_s[AW-1:0]];
                res_d   = ~stack_q[dm1_s[AW-1:0]];
                depth_d = dm1_s;
                tos_d   = (depth_q >= D_TWO) ? stack_q[dm2_s[AW-1:0]] : '0;
                state_d = (op_s == OP_DROP) ? S_FETCH : S_PUSH;
            end
            S_PUSH: begin
                wr_en_s = 1'b1;
                if (op_s == OP_SWAP) begin
                    wr_data_s = b_q;
                end else if (op_s == OP_DUP) begin
                    wr_data_s = a_q;
                end else if (op_s == OP_PUSH) begin
                    wr_data_s = DATA_WIDTH'($signed(instr_q[IMMW-1:0]));
                end else begin
                    wr_data_s = res_q;
                end
                depth_d = depth_q + D_ONE;
                tos_d   = wr_data_s;
                state_d = (op_s == OP_SWAP || op_s == OP_DUP) ? S_PUSH2 : S_FETCH;
            end
            S_PUSH2: begin
                wr_en_s   = 1'b1;
                wr_data_s = a_q;
                depth_d   = depth_q + D_ONE;
                tos_d     = a_q;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
        busy_d   = !(state_d == S_FETCH || state_d == S_HALT || state_d == S_ERROR);
        halted_d = halted_q | (state_d == S_HALT);
    end

    // Control and status registers; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            instr_q    <= '0;
            depth_q    <= '0;
            tos_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            depth_q    <= depth_d;
            tos_q      <= tos_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
        end
    end

    // Stack storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            stack_q[depth_q[AW-1:0]] <= wr_data_s;
        end
    end

    assign instr_ready = (state_q == S_FETCH) && !reset;
    assign tos         = tos_q;
    assign depth       = depth_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_stack_exec_unit.sv
// Directed scoreboard bench for stack_exec_unit: expected tos/depth/latency are queued
// when an instruction is offered and compared when the unit becomes ready again.
module tb_stack_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [31:0] tos;
    logic [4:0]  depth;
    logic        busy, halted, err;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] tos;
        logic [4:0]  depth;
        int          lat;
        logic [2:0]  code;
    } exp_t;
    exp_t sb[$];

    localparam logic [4:0] PUSH = 5'b00000, ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011;
    localparam logic [4:0] DIV  = 5'b00100, INV = 5'b01000, DUP = 5'b01001, SWAP = 5'b01010;
    localparam logic [4:0] DROP = 5'b01011, HALT = 5'b11111, ILL = 5'b10000;

    stack_exec_unit #(.DATA_WIDTH(32), .STACK_DEPTH(16), .INSTR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .tos(tos), .depth(depth), .busy(busy),
        .halted(halted), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with reset released
    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", {63'd0, instr_ready}, 64'd0);
        chk("rst_depth", {59'd0, depth}, 64'd0);
        chk("rst_tos", {32'd0, tos}, 64'd0);
        chk("rst_flags", {60'd0, busy, halted, err, 1'b0}, 64'd0);
        chk("rst_code", {61'd0, err_code}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_high", {63'd0, instr_ready}, 64'd1);
    endtask

    // Offer one instruction and complete the handshake; returns at the first negedge after it
    task automatic offer(input logic [4:0] op, input logic [10:0] imm);
        chk("ready_before", {63'd0, instr_ready}, 64'd1);
        instr = {op, imm};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic exec(input logic [4:0] op, input logic [10:0] imm,
                        input logic [31:0] etos, input logic [4:0] edep, input int elat);
        exp_t e;
        int lat;
        sb.push_back('{etos, edep, elat, 3'd0});
        offer(op, imm);
        chk("busy_decode", {63'd0, busy}, 64'd1);
        lat = 1;
        while (!instr_ready && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("tos", {32'd0, tos}, {32'd0, e.tos});
        chk("depth", {59'd0, depth}, {59'd0, e.depth});
        chk("err_clear", {63'd0, err}, 64'd0);
    endtask

    task automatic exec_err(input logic [4:0] op, input logic [10:0] imm, input logic [2:0] ecode,
                            input logic [31:0] etos, input logic [4:0] edep);
        exp_t e;
        int n;
        sb.push_back('{etos, edep, 2, ecode});
        offer(op, imm);
        n = 0;
        while (!err && n < 10) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("err_set", {63'd0, err}, 64'd1);
        chk("err_code", {61'd0, err_code}, {61'd0, e.code});
        chk("err_depth", {59'd0, depth}, {59'd0, e.depth});
        chk("err_tos", {32'd0, tos}, {32'd0, e.tos});
        repeat (3) @(negedge clk);
        chk("err_ready_low", {63'd0, instr_ready}, 64'd0);
        chk("err_sticky", {60'd0, err, busy, err_code[1:0]}, {60'd0, 1'b1, 1'b0, e.code[1:0]});
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'd0;
        @(negedge clk);
        do_reset();

        exec(PUSH, 11'd5, 32'd5, 5'd1, 3);
        exec(PUSH, 11'd3, 32'd3, 5'd2, 3);
        exec(SUB, 11'd0, 32'd2, 5'd1, 4);

        do_reset();
        exec(PUSH, 11'h7FF, 32'hFFFF_FFFF, 5'd1, 3);
        exec(PUSH, 11'd2, 32'd2, 5'd2, 3);
        exec(MUL, 11'd0, 32'hFFFF_FFFE, 5'd1, 4);
        exec(INV, 11'd0, 32'h0000_0001, 5'd1, 4);

        do_reset();
        exec(PUSH, 11'd7, 32'd7, 5'd1, 3);
        exec(PUSH, 11'd9, 32'd9, 5'd2, 3);
        exec(SWAP, 11'd0, 32'd7, 5'd2, 5);
        exec(DUP, 11'd0, 32'd7, 5'd3, 5);
        exec(DROP, 11'd0, 32'd7, 5'd2, 3);
        exec(DROP, 11'd0, 32'd9, 5'd1, 3);

        do_reset();
        exec_err(ADD, 11'd0, 3'd1, 32'd0, 5'd0);
        do_reset();

        for (int i = 1; i <= 16; i++) exec(PUSH, 11'd1, 32'd1, 5'(i), 3);
        exec_err(PUSH, 11'd1, 3'd2, 32'd1, 5'd16);

        do_reset();
        exec(PUSH, 11'd8, 32'd8, 5'd1, 3);
        exec(PUSH, 11'd0, 32'd0, 5'd2, 3);
        exec_err(DIV, 11'd0, 3'd3, 32'd0, 5'd2);

        do_reset();
        exec_err(ILL, 11'd0, 3'd4, 32'd0, 5'd0);

        do_reset();
        exec(PUSH, 11'd4, 32'd4, 5'd1, 3);
        offer(HALT, 11'd0);
        repeat (2) @(negedge clk);
        chk("halted", {63'd0, halted}, 64'd1);
        chk("halt_busy", {63'd0, busy}, 64'd0);
        instr = {PUSH, 11'd6};
        instr_valid = 1'b1;
        repeat (4) @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_ready_low", {63'd0, instr_ready}, 64'd0);
        chk("halt_depth", {59'd0, depth}, 64'd1);
        chk("halt_tos", {32'd0, tos}, 64'd4);

        do_reset();
        exec(PUSH, 11'd4, 32'd4, 5'd1, 3);
        exec(PUSH, 11'd1, 32'd1, 5'd2, 3);
        exec(PUSH, 11'd2, 32'd2, 5'd3, 3);
        offer(ADD, 11'd0);
        @(negedge clk);
        chk("pop2_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_reset", {63'd0, instr_ready}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_depth", {59'd0, depth}, 64'd0);
        chk("abort_tos", {32'd0, tos}, 64'd0);
        chk("abort_fetch", {62'd0, instr_ready, busy}, 64'd2);
        exec(PUSH, 11'd3, 32'd3, 5'd1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
